// File: rtl/ibex_mem_resp_pkg.sv
// Shared types and helpers for the Ibex bus memory responder.
package ibex_mem_resp_pkg;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    // Check bits of the all-zero word under the inverted SECDED code.
    localparam logic [6:0] IntgZero = 7'h2A;

    function automatic logic [31:0] addr_to_idx(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/ibex_mem_resp_pipe.sv
// Fixed-depth valid-tagged response delay line, flushed by synchronous reset.
module ibex_mem_resp_pipe
    import ibex_mem_resp_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  valid_i,
    input  resp_t resp_i,
    output logic  valid_o,
    output resp_t resp_o
);

    logic [Depth-1:0] valid_r;
    resp_t            resp_r [Depth];

    // Shift register; a flush drops every in-flight response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                valid_r[i] <= 1'b0;
                resp_r[i]  <= '0;
            end
        end else begin
            valid_r[0] <= valid_i;
            resp_r[0]  <= resp_i;
            for (int i = 1; i < Depth; i++) begin
                valid_r[i] <= valid_r[i-1];
                resp_r[i]  <= resp_r[i-1];
            end
        end
    end

    assign valid_o = valid_r[Depth-1];
    assign resp_o  = resp_r[Depth-1];

endmodule

// File: rtl/prim_secded_inv_39_32_enc.sv
// Inverted Hsiao (39,32) SECDED encoder: codeword = {check[6:0], data[31:0]}.
module prim_secded_inv_39_32_enc (
    input  logic [31:0] data_i,
    output logic [38:0] data_o
);

    logic [6:0] check_s;

    // Parity over each check bit's data columns, then the inversion pattern.
    always_comb begin
        check_s[0] = ^(data_i & 32'h2606_BD25);
        check_s[1] = ^(data_i & 32'hDEBA_8050);
        check_s[2] = ^(data_i & 32'h413D_89AA);
        check_s[3] = ^(data_i & 32'h3123_4ED1);
        check_s[4] = ^(data_i & 32'hC2C1_323B);
        check_s[5] = ^(data_i & 32'h2DCC_624C);
        check_s[6] = ^(data_i & 32'h9850_5586);
        data_o     = {check_s ^ 7'h2A, data_i};
    end

endmodule

// File: rtl/ibex_mem_responder.sv
// Word-addressed RAM behind an Ibex req/gnt/rvalid port with fixed-latency,
// integrity-protected responses and a bounded number of outstanding requests.
module ibex_mem_responder
    import ibex_mem_resp_pkg::*;
#(
    parameter logic [31:0] BaseAddr       = 32'h0010_0000,
    parameter int unsigned MemWords       = 1024,
    parameter int unsigned RespLatency    = 2,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [6:0]  wdata_intg_i,
    input  logic        stall_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic [6:0]  rdata_intg_o,
    output logic        err_o,
    output logic        intg_err_o
);

    localparam int unsigned IdxW       = $clog2(MemWords);
    localparam int unsigned OutW       = $clog2(MaxOutstanding + 1);
    localparam logic [31:0] RangeBytes = 32'(4 * MemWords);

    logic [31:0]   mem_r [MemWords];
    logic [OutW-1:0] outstanding_r;
    logic          intg_err_r;

    logic          accept_s;
    logic [31:0]   offset_s;
    logic          in_range_s;
    logic [IdxW-1:0] idx_s;
    logic [38:0]   wr_code_s;
    logic          intg_ok_s;
    logic          wr_en_s;
    resp_t         resp_in_s;
    resp_t         resp_out_s;
    logic [38:0]   rd_code_s;

    assign gnt_o    = req_i & ~stall_i & ~rst_i & (outstanding_r < OutW'(MaxOutstanding));
    assign accept_s = req_i & gnt_o;

    // Unsigned subtraction: addresses below the base wrap high and fall out of range.
    assign offset_s   = addr_i - BaseAddr;
    assign in_range_s = offset_s < RangeBytes;
    assign idx_s      = IdxW'(addr_to_idx(addr_i, BaseAddr));

    prim_secded_inv_39_32_enc u_wr_enc (
        .data_i (wdata_i),
        .data_o (wr_code_s)
    );

    assign intg_ok_s = (wr_code_s == {wdata_intg_i, wdata_i});
    assign wr_en_s   = accept_s & we_i & in_range_s & intg_ok_s;

    // Byte-masked RAM write; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Response formed in the accept cycle; idle slots carry zeros.
    always_comb begin
        resp_in_s = '0;
        if (accept_s) begin
            if (we_i) begin
                resp_in_s.err   = ~in_range_s | ~intg_ok_s;
                resp_in_s.rdata = 32'h0000_0000;
            end else if (in_range_s) begin
                resp_in_s.err   = 1'b0;
                resp_in_s.rdata = mem_r[idx_s];
            end else begin
                resp_in_s.err   = 1'b1;
                resp_in_s.rdata = 32'h0000_0000;
            end
        end else begin
            resp_in_s = '0;
        end
    end

    ibex_mem_resp_pipe #(
        .Depth (RespLatency)
    ) u_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (accept_s),
        .resp_i  (resp_in_s),
        .valid_o (rvalid_o),
        .resp_o  (resp_out_s)
    );

    // Granted-but-unanswered count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_r <= '0;
        end else begin
            case ({accept_s, rvalid_o})
                2'b10:   outstanding_r <= outstanding_r + OutW'(1);
                2'b01:   outstanding_r <= outstanding_r - OutW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Flag a write whose integrity does not match, regardless of address.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            intg_err_r <= 1'b0;
        end else begin
            intg_err_r <= accept_s & we_i & ~intg_ok_s;
        end
    end

    assign intg_err_o = intg_err_r;
    assign err_o      = resp_out_s.err;

    prim_secded_inv_39_32_enc u_rd_enc (
        .data_i (resp_out_s.rdata),
        .data_o (rd_code_s)
    );

    assign {rdata_intg_o, rdata_o} = rd_code_s;

endmodule
